uart_response_framer: RTL and testbench

UART_RESPONSE_FRAMER -- requirements
Module: uart_response_framer

---
 rtl/uart_proto_pkg.sv | 57 +++++
 rtl/uart_frame_const_rom.sv | 57 +++++
 rtl/uart_response_framer.sv | 190 +++++++++++++++++++
 tb/tb_uart_response_framer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_proto_pkg.sv
// Shared protocol definitions for the UART response framer: command codes,
// ASCII constants, frame geometry, FSM state encoding and the const-ROM
// entry format. The checksum field is present only with UART_RESP_CKSUM_EN.
package uart_proto_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h10;
  localparam logic [7:0] CMD_READ   = 8'h11;
  localparam logic [7:0] CMD_WRITE  = 8'h20;
  localparam logic [7:0] CMD_ACK    = 8'h21;

  localparam logic [7:0] CH_LBRK  = 8'h5B;
  localparam logic [7:0] CH_RBRK  = 8'h5D;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_NL    = 8'h0A;

  // "[CMD:hh] [LEN:hhhh] [" is always 21 bytes; the suffix depends on the build
  localparam int PRE_LEN = 21;
`ifdef UART_RESP_CKSUM_EN
  localparam int SUF_LEN = 13;
`else
  localparam int SUF_LEN = 2;
`endif
  localparam int FIXED_LEN = PRE_LEN + SUF_LEN;
  localparam int IDX_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_PAYLOAD,
    ST_SUFFIX
  } state_e;

  // ROM slot kind: a literal character or a hex nibble taken from frame state
  typedef enum logic [3:0] {
    SL_LIT,
    SL_CMD_HI,
    SL_CMD_LO,
    SL_LEN_3,
    SL_LEN_2,
    SL_LEN_1,
    SL_LEN_0,
    SL_CK_HI,
    SL_CK_LO
  } slot_e;

  typedef struct packed {
    slot_e      slot;
    logic [7:0] ch;
  } rom_ent_t;

  // Uppercase ASCII hex digit
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_frame_const_rom.sv
// Fixed PREFIX (indices 0..20) and SUFFIX (21..) characters of a response
// frame, with hex-digit positions flagged by slot kind. The checksum field of
// the suffix exists only with UART_RESP_CKSUM_EN.
module uart_frame_const_rom
  import uart_proto_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output rom_ent_t         ent
);

  // Index decode into literal char or hex slot
  always_comb begin
    ent = '{slot: SL_LIT, ch: 8'h00};
    case (idx)
      6'd0:  ent.ch = CH_LBRK;
      6'd1:  ent.ch = "C";
      6'd2:  ent.ch = "M";
      6'd3:  ent.ch = "D";
      6'd4:  ent.ch = CH_COLON;
      6'd5:  ent.slot = SL_CMD_HI;
      6'd6:  ent.slot = SL_CMD_LO;
      6'd7:  ent.ch = CH_RBRK;
      6'd8:  ent.ch = CH_SPACE;
      6'd9:  ent.ch = CH_LBRK;
      6'd10: ent.ch = "L";
      6'd11: ent.ch = "E";
      6'd12: ent.ch = "N";
      6'd13: ent.ch = CH_COLON;
      6'd14: ent.slot = SL_LEN_3;
      6'd15: ent.slot = SL_LEN_2;
      6'd16: ent.slot = SL_LEN_1;
      6'd17: ent.slot = SL_LEN_0;
      6'd18: ent.ch = CH_RBRK;
      6'd19: ent.ch = CH_SPACE;
      6'd20: ent.ch = CH_LBRK;
      6'd21: ent.ch = CH_RBRK;
`ifdef UART_RESP_CKSUM_EN
      6'd22: ent.ch = CH_SPACE;
      6'd23: ent.ch = CH_LBRK;
      6'd24: ent.ch = "C";
      6'd25: ent.ch = "K";
      6'd26: ent.ch = "S";
      6'd27: ent.ch = "U";
      6'd28: ent.ch = "M";
      6'd29: ent.ch = CH_COLON;
      6'd30: ent.slot = SL_CK_HI;
      6'd31: ent.slot = SL_CK_LO;
      6'd32: ent.ch = CH_RBRK;
      6'd33: ent.ch = CH_NL;
`else
      6'd22: ent.ch = CH_NL;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_response_framer.sv
// Streams an ASCII response frame "[CMD:hh] [LEN:hhhh] [<payload>]..." to a
// UART byte sink through a single registered output slot (1 byte/cycle when
// the sink is always ready). Define UART_RESP_CKSUM_EN to append the
// " [CKSUM:hh]" field; otherwise the frame ends with "]\n".
module uart_response_framer
  import uart_proto_pkg::*;
#(
  parameter int MAX_LEN = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req_cmd,
  input  logic [15:0] req_len,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        err_len
);

  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_LEN - 1);
  localparam logic [IDX_W-1:0] FRAME_END = IDX_W'(FIXED_LEN);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [15:0]      len_q, len_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             err_q, err_d;
  logic             init_q;
`ifdef UART_RESP_CKSUM_EN
  logic [7:0]       cksum_q, cksum_d;
`endif

  rom_ent_t   rom_ent;
  logic [7:0] rom_char;
  logic       load;
  logic       accept;
  logic       len_bad;

  uart_frame_const_rom u_rom (
    .idx (pos_q),
    .ent (rom_ent)
  );

  // Output slot can take a new byte when empty or draining this cycle
  assign load    = !tx_valid_q || uart_tx_ready;
  assign accept  = req_valid && req_ready;
  assign len_bad = 32'(req_len) > 32'(MAX_LEN);

  // Resolve hex slots of the fixed text against the captured request
  always_comb begin
    rom_char = rom_ent.ch;
    case (rom_ent.slot)
      SL_CMD_HI: rom_char = hex_ascii(cmd_q[7:4]);
      SL_CMD_LO: rom_char = hex_ascii(cmd_q[3:0]);
      SL_LEN_3:  rom_char = hex_ascii(len_q[15:12]);
      SL_LEN_2:  rom_char = hex_ascii(len_q[11:8]);
      SL_LEN_1:  rom_char = hex_ascii(len_q[7:4]);
      SL_LEN_0:  rom_char = hex_ascii(len_q[3:0]);
`ifdef UART_RESP_CKSUM_EN
      SL_CK_HI:  rom_char = hex_ascii(cksum_q[7:4]);
      SL_CK_LO:  rom_char = hex_ascii(cksum_q[3:0]);
`endif
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      init_q     <= 1'b0;
`ifdef UART_RESP_CKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      init_q     <= 1'b1;
`ifdef UART_RESP_CKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  // Next state, output-slot loading and checksum accumulation
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = load ? 1'b0 : tx_valid_q;
    err_d      = 1'b0;
`ifdef UART_RESP_CKSUM_EN
    cksum_d    = cksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            // ROM entry 0 is the literal "[", so it needs no captured state
            cmd_d      = req_cmd;
            len_d      = req_len;
            cnt_d      = '0;
            tx_data_d  = rom_char;
            tx_valid_d = 1'b1;
            pos_d      = IDX_W'(1);
            state_d    = ST_PREFIX;
`ifdef UART_RESP_CKSUM_EN
            cksum_d    = req_cmd + req_len[7:0] + req_len[15:8];
`endif
          end
        end
      end
      ST_PREFIX: begin
        if (load) begin
          tx_data_d  = rom_char;
          tx_valid_d = 1'b1;
          pos_d      = pos_q + IDX_W'(1);
          if (pos_q == PRE_LAST)
            state_d = (len_q == 16'd0) ? ST_SUFFIX : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (pl_valid && pl_ready) begin
          tx_data_d  = pl_data;
          tx_valid_d = 1'b1;
          cnt_d      = cnt_q + 16'd1;
`ifdef UART_RESP_CKSUM_EN
          cksum_d    = cksum_q + pl_data;
`endif
          if (cnt_q + 16'd1 == len_q) state_d = ST_SUFFIX;
        end
      end
      ST_SUFFIX: begin
        if (pos_q != FRAME_END) begin
          if (load) begin
            tx_data_d  = rom_char;
            tx_valid_d = 1'b1;
            pos_d      = pos_q + IDX_W'(1);
          end
        end else if (frame_done) begin
          state_d = ST_IDLE;
          pos_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    req_ready  = init_q && (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    pl_ready   = (state_q == ST_PAYLOAD) && load;
    frame_done = (state_q == ST_SUFFIX) && (pos_q == FRAME_END) &&
                 tx_valid_q && uart_tx_ready;
  end

  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = tx_valid_q;
  assign err_len       = err_q;

endmodule

// File: tb/tb_uart_response_framer.sv
// Bench for uart_response_framer: directed and randomized frames checked
// against a string-level frame model; random sink backpressure and payload gaps.
module tb_uart_response_framer;
  import uart_proto_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req_cmd;
  logic [15:0] req_len;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic        busy;
  logic        frame_done;
  logic        err_len;

  always #5 clk = ~clk;

  uart_response_framer #(.MAX_LEN(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_cmd(req_cmd), .req_len(req_len), .req_valid(req_valid), .req_ready(req_ready),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .busy(busy), .frame_done(frame_done), .err_len(err_len)
  );

  int checks = 0;
  int failures = 0;
  int rdy_pct = 100;
  int gap_pct = 0;
  logic [7:0] pl_src[$];
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int cyc = 0, first_cyc = 0, last_cyc = 0;
  int valid_cyc = 0, stall_viol = 0, done_cnt = 0, done_idx = 0, done_bad = 0;
  int err_cnt = 0, pl_pops = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;
  string HEXS = "0123456789ABCDEF";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Drives sink ready / payload at negedge, then samples what the next edge will transfer
  always begin
    @(negedge clk);
    uart_tx_ready = ($urandom_range(0, 99) < rdy_pct);
    if (pl_src.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      pl_valid = 1'b1;
      pl_data  = pl_src[0];
    end else begin
      pl_valid = 1'b0;
      pl_data  = 8'h00;
    end
    #1;
    cyc++;
    if (rst_n) begin
      if (uart_tx_valid) valid_cyc++;
      if (hold_pend && (!uart_tx_valid || uart_tx_data !== hold_data)) stall_viol++;
      hold_pend = uart_tx_valid && !uart_tx_ready;
      hold_data = uart_tx_data;
      if (uart_tx_valid && uart_tx_ready) begin
        rx_q.push_back(uart_tx_data);
        if (rx_q.size() == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        done_idx = rx_q.size();
        if (!(uart_tx_valid && uart_tx_ready)) done_bad++;
      end
      if (err_len) err_cnt++;
      if (pl_valid && pl_ready) begin
        void'(pl_src.pop_front());
        pl_pops++;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_hex(input int v, input int nd);
    for (int i = nd - 1; i >= 0; i--) exp_q.push_back(HEXS[(v >> (4 * i)) & 15]);
  endtask

  // Reference frame built from the textual frame format
  task automatic build_exp(input logic [7:0] cmd, input int len);
`ifdef UART_RESP_CKSUM_EN
    int sum;
`endif
    exp_q.delete();
    push_str("[CMD:");
    push_hex(int'(cmd), 2);
    push_str("] [LEN:");
    push_hex(len, 4);
    push_str("] [");
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
`ifdef UART_RESP_CKSUM_EN
    sum = int'(cmd) + (len % 256) + (len / 256);
    foreach (pay_q[i]) sum += int'(pay_q[i]);
    push_str("] [CKSUM:");
    push_hex(sum % 256, 2);
    push_str("]\n");
`else
    push_str("]\n");
`endif
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int len, input int rp, input int gp,
                           input int abort_at, input bit consec);
    int t;
    int bad;
    rdy_pct = rp;
    gap_pct = gp;
    build_exp(cmd, len);
    pl_src = pay_q;
    rx_q.delete();
    done_cnt = 0; done_bad = 0; done_idx = 0; pl_pops = 0; stall_viol = 0;
    chk("idle_ready", 32'(req_ready), 1);
    req_cmd   = cmd;
    req_len   = 16'(len);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_cmd   = 8'($urandom);
    req_len   = 16'($urandom);
    chk("first_valid", 32'(uart_tx_valid), 1);
    chk("first_byte", 32'(uart_tx_data), 32'h5B);
    chk("busy_on", 32'(busy), 1);
    if (abort_at >= 0) begin
      t = 0;
      while (pl_pops < abort_at && t < 2000) begin tick(); t++; end
      chk("abort_reach", 32'(pl_pops >= abort_at), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_tx_valid", 32'(uart_tx_valid), 0);
      chk("rst_tx_data", 32'(uart_tx_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_pl_ready", 32'(pl_ready), 0);
      pl_src.delete();
      tick();
      rst_n = 1'b1;
      #1;
      chk("rel_ready_low", 32'(req_ready), 0);
      tick();
      chk("rel_ready_high", 32'(req_ready), 1);
      return;
    end
    t = 0;
    while (done_cnt == 0 && t < 20000) begin tick(); t++; end
    chk("frame_len", 32'(rx_q.size()), 32'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad++;
    chk("frame_bytes_bad", 32'(bad), 0);
    chk("done_count", 32'(done_cnt), 1);
    chk("done_on_last", 32'(done_idx), 32'(exp_q.size()));
    chk("done_w_xfer", 32'(done_bad), 0);
    chk("pl_consumed", 32'(pl_pops), 32'(len));
    if (consec) chk("consecutive", 32'(last_cyc - first_cyc + 1), 32'(exp_q.size()));
    tick();
    chk("busy_off", 32'(busy), 0);
    chk("ready_back", 32'(req_ready), 1);
  endtask

  task automatic rand_pay(input int n);
    pay_q.delete();
    repeat (n) pay_q.push_back(8'($urandom));
  endtask

  initial begin
    logic [7:0] cmds[4];
    cmds = '{CMD_STATUS, CMD_READ, CMD_WRITE, CMD_ACK};
    rst_n = 1'b0;
    req_cmd = 8'h00; req_len = 16'h0000; req_valid = 1'b0;
    pl_data = 8'h00; pl_valid = 1'b0; uart_tx_ready = 1'b0;
    #1;
    chk("reset_tx_valid", 32'(uart_tx_valid), 0);
    chk("reset_tx_data", 32'(uart_tx_data), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_pl_ready", 32'(pl_ready), 0);
    chk("reset_done", 32'(frame_done), 0);
    chk("reset_err", 32'(err_len), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(req_ready), 1);

    // Empty payload, sink always ready
    pay_q.delete();
    run_frame(CMD_STATUS, 0, 100, 0, -1, 1'b1);

    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame(CMD_READ, 5, 100, 0, -1, 1'b1);

    pay_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame(CMD_WRITE, 4, 100, 0, -1, 1'b1);

    // Same payload with and without backpressure / payload gaps
    rand_pay(24);
    run_frame(CMD_ACK, 24, 100, 0, -1, 1'b1);
    run_frame(CMD_ACK, 24, 30, 40, -1, 1'b0);
    chk("stall_stable", 32'(stall_viol), 0);

    // Largest accepted length
    rand_pay(128);
    run_frame(CMD_READ, 128, 70, 20, -1, 1'b0);
    chk("stall_stable_max", 32'(stall_viol), 0);

    // Oversize request is rejected
    rdy_pct = 100; gap_pct = 0;
    valid_cyc = 0; err_cnt = 0;
    req_cmd = CMD_WRITE; req_len = 16'd129; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("err_pulse", 32'(err_len), 1);
    chk("err_ready", 32'(req_ready), 1);
    chk("err_busy", 32'(busy), 0);
    tick();
    chk("err_single", 32'(err_len), 0);
    repeat (10) tick();
    chk("err_no_bytes", 32'(valid_cyc), 0);
    chk("err_count", 32'(err_cnt), 1);

    // Reset in the middle of a payload, then a clean frame
    rand_pay(8);
    run_frame(CMD_WRITE, 8, 100, 0, 3, 1'b0);
    rand_pay(8);
    run_frame(CMD_WRITE, 8, 100, 0, -1, 1'b1);

    // Random frames
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(0, 40);
      rand_pay(n);
      run_frame(cmds[$urandom_range(0, 3)], n, $urandom_range(30, 100), $urandom_range(0, 50), -1, 1'b0);
    end
    chk("stall_stable_rand", 32'(stall_viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
